// File: rtl/cla_pkg.sv
// Shared definitions for the CLA response checker: default widths and FSM encoding.
package cla_pkg;

    localparam int CLA_WIDTH = 8;
    localparam int CLA_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : cla_pkg

// File: rtl/cla_stim_pipe.sv
// LATENCY-stage delay line for accepted stimulus beats {valid, a, b, cin}.
// LATENCY=0 is a pure pass-through; reset only clears the valid bits since
// operands are don't-care when their valid bit is low.
module cla_stim_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin
);

    generate
        if (LATENCY == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_a     = in_a;
            assign out_b     = in_b;
            assign out_cin   = in_cin;
        end else begin : g_stages
            logic             valid_reg [LATENCY];
            logic [WIDTH-1:0] a_reg     [LATENCY];
            logic [WIDTH-1:0] b_reg     [LATENCY];
            logic             cin_reg   [LATENCY];

            // Valid bits shift every cycle and are flushed by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        valid_reg[i] <= 1'b0;
                    end
                end else begin
                    valid_reg[0] <= in_valid;
                    for (int i = 1; i < LATENCY; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                    end
                end
            end

            // Operand stages travel alongside their valid bit; no reset needed.
            always_ff @(posedge clk) begin
                a_reg[0]   <= in_a;
                b_reg[0]   <= in_b;
                cin_reg[0] <= in_cin;
                for (int i = 1; i < LATENCY; i++) begin
                    a_reg[i]   <= a_reg[i-1];
                    b_reg[i]   <= b_reg[i-1];
                    cin_reg[i] <= cin_reg[i-1];
                end
            end

            assign out_valid = valid_reg[LATENCY-1];
            assign out_a     = a_reg[LATENCY-1];
            assign out_b     = b_reg[LATENCY-1];
            assign out_cin   = cin_reg[LATENCY-1];
        end
    endgenerate

endmodule : cla_stim_pipe

// File: rtl/cla8_response_checker.sv
// Self-contained checker for a CLA adder: accepts stimulus beats, delays them to
// line up with the adder's result, compares against an internal reference sum
// and keeps saturating counters plus a capture of the first failing beat.
module cla8_response_checker
    import cla_pkg::*;
#(
    parameter int WIDTH   = CLA_WIDTH,
    parameter int CNT_W   = CLA_CNT_W,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] stim_a,
    input  logic [WIDTH-1:0] stim_b,
    input  logic             stim_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cout_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic             first_fail_cin,
    output logic [WIDTH:0]   first_fail_sum
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] sample_count_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [CNT_W-1:0] cout_count_reg;
    logic [CNT_W-1:0] ff_idx_reg;
    logic [WIDTH-1:0] ff_a_reg;
    logic [WIDTH-1:0] ff_b_reg;
    logic             ff_cin_reg;
    logic [WIDTH:0]   ff_sum_reg;

    logic             start_accept;
    logic             accept;
    logic             last_issue;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_a;
    logic [WIDTH-1:0] chk_b;
    logic             chk_cin;
    logic [WIDTH:0]   exp_result;
    logic [WIDTH:0]   dut_result;
    logic             mismatch;

    assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign accept       = stim_valid && ready;
    assign last_issue   = accept && ((issued_reg + 1'b1) == target_reg);

    cla_stim_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_a      (stim_a),
        .in_b      (stim_b),
        .in_cin    (stim_cin),
        .out_valid (chk_valid),
        .out_a     (chk_a),
        .out_b     (chk_b),
        .out_cin   (chk_cin)
    );

    // Reference sum is carried one bit wider so the carry-out falls out naturally.
    assign exp_result = {1'b0, chk_a} + {1'b0, chk_b} + {{WIDTH{1'b0}}, chk_cin};
    assign dut_result = {dut_cout, dut_sum};
    assign mismatch   = (exp_result != dut_result);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured when no run is in progress.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sample_count_reg == target_reg) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ready = (state_reg == ST_RUN) && (issued_reg < target_reg);
        busy  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
        done  = (state_reg == ST_DONE);
        pass  = (state_reg == ST_DONE) && (err_count_reg == '0);
    end

    // Run bookkeeping, saturating counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            issued_reg       <= '0;
            sample_count_reg <= '0;
            err_count_reg    <= '0;
            cout_count_reg   <= '0;
            ff_idx_reg       <= '0;
            ff_a_reg         <= '0;
            ff_b_reg         <= '0;
            ff_cin_reg       <= 1'b0;
            ff_sum_reg       <= '0;
            target_reg       <= rst ? '0 : num_samples;
        end else begin
            if (accept) begin
                issued_reg <= issued_reg + 1'b1;
            end
            if (chk_valid) begin
                if (sample_count_reg != '1) begin
                    sample_count_reg <= sample_count_reg + 1'b1;
                end
                if (mismatch && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
                if (exp_result[WIDTH] && (cout_count_reg != '1)) begin
                    cout_count_reg <= cout_count_reg + 1'b1;
                end
                if (mismatch && (err_count_reg == '0)) begin
                    ff_idx_reg <= sample_count_reg;
                    ff_a_reg   <= chk_a;
                    ff_b_reg   <= chk_b;
                    ff_cin_reg <= chk_cin;
                    ff_sum_reg <= dut_result;
                end
            end
        end
    end

    assign sample_count   = sample_count_reg;
    assign err_count      = err_count_reg;
    assign cout_count     = cout_count_reg;
    assign first_fail_idx = ff_idx_reg;
    assign first_fail_a   = ff_a_reg;
    assign first_fail_b   = ff_b_reg;
    assign first_fail_cin = ff_cin_reg;
    assign first_fail_sum = ff_sum_reg;

endmodule : cla8_response_checker

// File: tb/tb_cla8_response_checker.sv
// Directed bench: three checker instances with LATENCY 0, 1 and 2 share one
// stimulus bus; each instance is started on its own.
module tb_cla8_response_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_samples;
    logic        stim_valid;
    logic [7:0]  stim_a;
    logic [7:0]  stim_b;
    logic        stim_cin;
    logic [8:0]  res0;
    logic [8:0]  model;
    logic [8:0]  d1_q;
    logic [8:0]  d2_q;

    logic        start_w          [3];
    logic [7:0]  dut_sum_w        [3];
    logic        dut_cout_w       [3];
    logic        ready_w          [3];
    logic        busy_w           [3];
    logic        done_w           [3];
    logic        pass_w           [3];
    logic [15:0] sample_count_w   [3];
    logic [15:0] err_count_w      [3];
    logic [15:0] cout_count_w     [3];
    logic [15:0] first_fail_idx_w [3];
    logic [7:0]  first_fail_a_w   [3];
    logic [7:0]  first_fail_b_w   [3];
    logic        first_fail_cin_w [3];
    logic [8:0]  first_fail_sum_w [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Registered adder model feeding the delayed instances.
    assign model = 9'(stim_a) + 9'(stim_b) + 9'(stim_cin);
    always @(posedge clk) begin
        d1_q <= model;
        d2_q <= d1_q;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            if (gi == 0) begin : g_l0
                assign {dut_cout_w[gi], dut_sum_w[gi]} = res0;
            end else if (gi == 1) begin : g_l1
                assign {dut_cout_w[gi], dut_sum_w[gi]} = d1_q;
            end else begin : g_l2
                assign {dut_cout_w[gi], dut_sum_w[gi]} = d2_q;
            end

            cla8_response_checker #(
                .WIDTH   (8),
                .CNT_W   (16),
                .LATENCY (gi)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .start          (start_w[gi]),
                .num_samples    (num_samples),
                .stim_valid     (stim_valid),
                .stim_a         (stim_a),
                .stim_b         (stim_b),
                .stim_cin       (stim_cin),
                .dut_sum        (dut_sum_w[gi]),
                .dut_cout       (dut_cout_w[gi]),
                .ready          (ready_w[gi]),
                .busy           (busy_w[gi]),
                .done           (done_w[gi]),
                .pass           (pass_w[gi]),
                .sample_count   (sample_count_w[gi]),
                .err_count      (err_count_w[gi]),
                .cout_count     (cout_count_w[gi]),
                .first_fail_idx (first_fail_idx_w[gi]),
                .first_fail_a   (first_fail_a_w[gi]),
                .first_fail_b   (first_fail_b_w[gi]),
                .first_fail_cin (first_fail_cin_w[gi]),
                .first_fail_sum (first_fail_sum_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int k, input logic [15:0] n);
        num_samples = n;
        start_w[k]  = 1'b1;
        @(posedge clk);
        #1;
        start_w[k]  = 1'b0;
        $display("start inst=%0d num_samples=%0d", k, n);
    endtask

    // One beat; r is the hand-computed result presented by the LATENCY=0 adder.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] r);
        stim_valid = 1'b1;
        stim_a     = a;
        stim_b     = b;
        stim_cin   = c;
        res0       = r;
        @(posedge clk);
        #1;
        stim_valid = 1'b0;
        $display("beat a=%h b=%h cin=%b dut=%h", a, b, c, r);
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (!done_w[k] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_wait", 32'(done_w[k]), 1);
    endtask

    initial begin
        int miss;
        rst         = 1'b1;
        num_samples = '0;
        stim_valid  = 1'b0;
        stim_a      = '0;
        stim_b      = '0;
        stim_cin    = 1'b0;
        res0        = '0;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",  32'(done_w[0]), 0);
        chk("rst_pass",  32'(pass_w[0]), 0);
        chk("rst_ready", 32'(ready_w[0]), 0);
        chk("rst_busy",  32'(busy_w[2]), 0);
        chk("rst_cnt",   32'(sample_count_w[0]), 0);
        rst = 1'b0;

        // Basic run, LATENCY=0.
        start_run(0, 16'd4);
        chk("t1_busy",  32'(busy_w[0]), 1);
        chk("t1_ready", 32'(ready_w[0]), 1);
        beat(8'hF0, 8'hF0, 1'b1, 9'h1E1);
        beat(8'hF1, 8'hF1, 1'b1, 9'h1E3);
        beat(8'hF2, 8'hF2, 1'b1, 9'h1E5);
        beat(8'hF3, 8'hF3, 1'b1, 9'h1E7);
        chk("t1_ready_off", 32'(ready_w[0]), 0);
        wait_done(0);
        chk("t1_pass", 32'(pass_w[0]), 1);
        chk("t1_cnt",  32'(sample_count_w[0]), 4);
        chk("t1_cout", 32'(cout_count_w[0]), 4);
        chk("t1_err",  32'(err_count_w[0]), 0);

        // All-ones wrap case.
        start_run(0, 16'd2);
        chk("t2_done_drop", 32'(done_w[0]), 0);
        beat(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        beat(8'h00, 8'h00, 1'b1, 9'h001);
        wait_done(0);
        chk("t2_cout", 32'(cout_count_w[0]), 1);
        chk("t2_pass", 32'(pass_w[0]), 1);

        // Fault injection: sum bit0 forced low on the second beat.
        start_run(0, 16'd3);
        beat(8'h10, 8'h20, 1'b0, 9'h030);
        beat(8'hF1, 8'hF1, 1'b1, 9'h1E2);
        beat(8'h22, 8'h11, 1'b1, 9'h034);
        wait_done(0);
        chk("t3_err",    32'(err_count_w[0]), 1);
        chk("t3_idx",    32'(first_fail_idx_w[0]), 1);
        chk("t3_a",      32'(first_fail_a_w[0]), 32'hF1);
        chk("t3_b",      32'(first_fail_b_w[0]), 32'hF1);
        chk("t3_cin",    32'(first_fail_cin_w[0]), 1);
        chk("t3_sum",    32'(first_fail_sum_w[0]), 32'h1E2);
        chk("t3_pass",   32'(pass_w[0]), 0);

        // A later failure must not overwrite the capture.
        start_run(0, 16'd4);
        beat(8'h10, 8'h20, 1'b0, 9'h030);
        beat(8'hF1, 8'hF1, 1'b1, 9'h1E2);
        beat(8'h01, 8'h01, 1'b0, 9'h002);
        beat(8'h80, 8'h80, 1'b0, 9'h000);
        wait_done(0);
        chk("t3b_err",  32'(err_count_w[0]), 2);
        chk("t3b_idx",  32'(first_fail_idx_w[0]), 1);
        chk("t3b_a",    32'(first_fail_a_w[0]), 32'hF1);
        chk("t3b_sum",  32'(first_fail_sum_w[0]), 32'h1E2);
        chk("t3b_cout", 32'(cout_count_w[0]), 2);

        // Zero-length run, then a normal rerun.
        start_run(0, 16'd0);
        chk("t5_done", 32'(done_w[0]), 1);
        chk("t5_pass", 32'(pass_w[0]), 1);
        chk("t5_cnt",  32'(sample_count_w[0]), 0);
        chk("t5_err",  32'(err_count_w[0]), 0);
        chk("t5_idx",  32'(first_fail_idx_w[0]), 0);
        start_run(0, 16'd2);
        chk("t5_done_drop", 32'(done_w[0]), 0);
        chk("t5_busy",      32'(busy_w[0]), 1);
        beat(8'h01, 8'h02, 1'b0, 9'h003);
        beat(8'hC0, 8'h40, 1'b0, 9'h100);
        wait_done(0);
        chk("t5_cnt2",  32'(sample_count_w[0]), 2);
        chk("t5_pass2", 32'(pass_w[0]), 1);

        // LATENCY=2 sweep a=b=0..255, cin=0.
        start_run(2, 16'd256);
        miss = 0;
        for (int i = 0; i < 256; i++) begin
            if (!ready_w[2]) miss++;
            stim_valid = 1'b1;
            stim_a     = i[7:0];
            stim_b     = i[7:0];
            stim_cin   = 1'b0;
            @(posedge clk);
            #1;
        end
        stim_valid = 1'b0;
        $display("sweep 256 beats issued, ready misses=%0d", miss);
        chk("t4_ready_miss", 32'(miss), 0);
        chk("t4_ready_off",  32'(ready_w[2]), 0);
        chk("t4_drain_busy", 32'(busy_w[2]), 1);
        chk("t4_drain_cnt",  32'(sample_count_w[2]), 254);
        wait_done(2);
        chk("t4_cnt",  32'(sample_count_w[2]), 256);
        chk("t4_cout", 32'(cout_count_w[2]), 128);
        chk("t4_err",  32'(err_count_w[2]), 0);
        chk("t4_pass", 32'(pass_w[2]), 1);

        // LATENCY=1: reset after 5 beats, then a fresh run.
        start_run(1, 16'd10);
        for (int i = 0; i < 5; i++) beat(8'h90, 8'h90, 1'b0, 9'h120);
        chk("t6_pre_cnt", 32'(sample_count_w[1]), 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_busy",  32'(busy_w[1]), 0);
        chk("t6_ready", 32'(ready_w[1]), 0);
        chk("t6_done",  32'(done_w[1]), 0);
        chk("t6_cnt",   32'(sample_count_w[1]), 0);
        chk("t6_cout",  32'(cout_count_w[1]), 0);
        chk("t6_err",   32'(err_count_w[1]), 0);
        rst = 1'b0;
        start_run(1, 16'd3);
        for (int i = 0; i < 3; i++) beat(8'h90, 8'h90, 1'b0, 9'h120);
        wait_done(1);
        chk("t6_cnt2",  32'(sample_count_w[1]), 3);
        chk("t6_cout2", 32'(cout_count_w[1]), 3);
        chk("t6_pass2", 32'(pass_w[1]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cla8_response_checker

// File: doc/cla8_response_checker.md
Name: cla8_response_checker

Overview:
Receiving end of the CLA adder stimulus interface. It accepts stimulus beats (a, b, cin) together with the adder's result (sum, cout), computes the expected (WIDTH+1)-bit result internally, and keeps pass/fail, coverage and first-failure records over a programmed number of samples. It is synthesizable, so it can run next to any CLA instance in simulation or on FPGA, and it replaces eyeball checking of adder waveforms.

Parameters:
WIDTH, 8, operand and sum width.
CNT_W, 16, width of the sample, error and coverage counters.
LATENCY, 0, number of clk cycles from a stimulus beat to its DUT result. Legal range 0..3.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a run. Honoured in IDLE or DONE only.
num_samples  input  CNT_W  number of beats in the run. Sampled on start.
stim_valid  input  1  stimulus beat present.
stim_a  input  WIDTH  operand a.
stim_b  input  WIDTH  operand b.
stim_cin  input  1  carry in.
dut_sum  input  WIDTH  DUT sum, aligned LATENCY cycles after its beat.
dut_cout  input  1  DUT carry out, same alignment as dut_sum.
ready  output  1  checker accepts a beat this cycle.
busy  output  1  state is RUN or DRAIN.
done  output  1  state is DONE.
pass  output  1  done and err_count==0.
sample_count  output  CNT_W  beats checked.
err_count  output  CNT_W  mismatching beats.
cout_count  output  CNT_W  checked beats whose expected cout is 1.
first_fail_idx  output  CNT_W  index of the first mismatching beat, 0-based.
first_fail_a, first_fail_b  output  WIDTH  operands of the first failing beat.
first_fail_cin  output  1  cin of the first failing beat.
first_fail_sum  output  WIDTH+1  DUT result of the first failing beat, as {cout,sum}.

Behaviour:
- Reset: state IDLE. All outputs 0, all counters and capture registers 0, delay line emptied.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE with start: counters, capture registers and issued count are cleared; target is latched from num_samples; next state is RUN. If num_samples==0, next state is DONE instead, with pass=1.
  - RUN: ready = (issued < target). A beat is accepted when stim_valid && ready, and issued increments. When issued reaches target, next state is DRAIN. stim_valid is ignored while ready=0.
  - DRAIN: ready=0. When sample_count reaches target, next state is DONE.
  - DONE: all results hold until the next start.
  - start in RUN or DRAIN is ignored.
- Checking path: accepted beats enter a LATENCY-deep valid/operand shift register.
  - With LATENCY=0, the compare happens in the same cycle as the beat.
  - When the delayed valid is 1: exp = {1'b0,a} + {1'b0,b} + cin, computed WIDTH+1 wide; mismatch = (exp != {dut_cout,dut_sum}).
- Counter updates are registered on the compare cycle, so outputs appear 1 clk after the compare.
  - sample_count always increments.
  - err_count increments on mismatch.
  - cout_count increments when exp[WIDTH] is 1.
  - All counters saturate at all-ones and do not wrap.
- First-failure capture: written only on the first mismatch of a run, i.e. while err_count==0. Later mismatches do not overwrite it.
- Wrap-around: operands are arbitrary. The all-ones case 0xFF+0xFF+1 = 0x1FF must produce exp cout=1, sum=0xFF.
- Reset mid-run: everything returns to the reset state immediately and in-flight beats are discarded.
- pass and done drop in the cycle after a new start is accepted.

Decomposition:
- Shared package (cla_pkg): WIDTH default, state encoding constants (IDLE=0, RUN=1, DRAIN=2, DONE=3), and CNT_W default.
- One sub-module: cla_stim_pipe, a parameterised LATENCY-stage register for {valid,a,b,cin}. It must handle LATENCY=0 as a pass-through, and rst clears the valid bits.
- The FSM, comparator and counters stay in the top module.

Test Plan:
- LATENCY=0, num_samples=4, correct adder model, beats (F0,F0,1), (F1,F1,1), (F2,F2,1), (F3,F3,1). Required: expected results 1E1, 1E3, 1E5, 1E7; done=1, pass=1, sample_count=4, cout_count=4, err_count=0.
- Beat (FF,FF,1) with a correct result, then (00,00,1). Required: expected 1FF then 001; cout_count=1; pass=1.
- Fault injection: DUT sum bit0 forced to 0 on the second of 3 beats, beat (F1,F1,1). Required: err_count=1, first_fail_idx=1, first_fail_a=F1, first_fail_b=F1, first_fail_cin=1, first_fail_sum=1E2, pass=0. The capture must hold after a later failure.
- LATENCY=2 with a registered DUT model, 256 beats sweeping a=b from 0x00 to 0xFF, cin=0. Required: ready deasserts after beat 256; DRAIN lasts until count reaches 256; pass=1; cout_count=128.
- num_samples=0 then start. Required: done=1 and pass=1 one clk later, all counters 0. A second start with num_samples=2 clears done and reruns.
- rst asserted mid-run after 5 beats with LATENCY=1. Required: next cycle state is IDLE, all outputs 0; a following run counts from 0.
